sh7604_ibus_arb: RTL

Two-master arbiter in front of the SH7604 bus state controller. It merges the CPU/cache port (M0) and the DMAC port (M1) onto the single internal bus (`IBUS_*`) that the BSC consumes, and holds ownership across 4-longword cache-line bursts and locked read-modify-write sequences (TAS). Ownership is registered and is decided only on `CE_R` edges. The non-granted master is stalled through its `BUSY` output.

---
 rtl/sh7604_ibus_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sh7604_ibus_arb.sv
`default_nettype none
// ============================================================================
// Module   : sh7604_ibus_arb
// Purpose  : Two-master arbiter merging the CPU/cache port (M0) and the DMAC
//            port (M1) onto the single internal bus consumed by the SH7604
//            bus state controller. Ownership is registered, decided only on
//            CE_R, and held across 4-beat cache-line bursts and locked
//            read-modify-write (TAS) sequences.
// Ports    : CLK/RST/CE_R      clock, synchronous active-high reset, enable
//            M0_* / M1_*       master request fields in, DO/BUSY out
//            IBUS_*            muxed request to the BSC, DO/BUSY from BSC
//            OWNER             debug: 00 idle, 01 M0, 10 M1
// Revision : 1.0  initial release
// ============================================================================
module sh7604_ibus_arb #(
    parameter logic DMA_PRIO = 1'b1,
    parameter logic RR       = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [31:0] M0_A,
    input  logic [31:0] M0_DI,
    input  logic [3:0]  M0_BA,
    input  logic        M0_WE,
    input  logic        M0_REQ,
    input  logic        M0_BURST,
    input  logic        M0_LOCK,
    output logic [31:0] M0_DO,
    output logic        M0_BUSY,
    input  logic [31:0] M1_A,
    input  logic [31:0] M1_DI,
    input  logic [3:0]  M1_BA,
    input  logic        M1_WE,
    input  logic        M1_REQ,
    input  logic        M1_BURST,
    input  logic        M1_LOCK,
    output logic [31:0] M1_DO,
    output logic        M1_BUSY,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    output logic        IBUS_BURST,
    output logic        IBUS_LOCK,
    input  logic [31:0] IBUS_DO,
    input  logic        IBUS_BUSY,
    output logic [1:0]  OWNER
);

    // Encoding doubles as the OWNER debug value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic       last_q, last_d;   // 0 = M0 owned last, 1 = M1 owned last

    logic w_own0, w_own1, w_owned;
    logic w_req, w_burst, w_lock, w_done, w_pick_m1;

    assign w_own0  = (state_q == OWN0);
    assign w_own1  = (state_q == OWN1);
    assign w_owned = w_own0 | w_own1;

    // Fields of the current owner; only meaningful while a master owns.
    assign w_req   = w_own1 ? M1_REQ   : M0_REQ;
    assign w_burst = w_own1 ? M1_BURST : M0_BURST;
    assign w_lock  = w_own1 ? M1_LOCK  : M0_LOCK;
    assign w_done  = w_owned & w_req & ~IBUS_BUSY;

    // Tie-break for simultaneous requests.
    assign w_pick_m1 = RR ? ~last_q : DMA_PRIO;

    // ------------------------------------------------------------------
    // Slave-side mux: idle presents M0 fields with the request qualifiers
    // forced low so the BSC never sees a request between owners.
    // ------------------------------------------------------------------
    assign IBUS_A     = w_own1 ? M1_A  : M0_A;
    assign IBUS_DI    = w_own1 ? M1_DI : M0_DI;
    assign IBUS_BA    = w_own1 ? M1_BA : M0_BA;
    assign IBUS_WE    = w_own1 ? M1_WE : M0_WE;
    assign IBUS_REQ   = w_owned & w_req;
    assign IBUS_BURST = w_owned & w_burst;
    assign IBUS_LOCK  = w_owned & w_lock;

    assign M0_DO   = IBUS_DO;
    assign M1_DO   = IBUS_DO;
    assign M0_BUSY = M0_REQ & ~(w_own0 & ~IBUS_BUSY);
    assign M1_BUSY = M1_REQ & ~(w_own1 & ~IBUS_BUSY);
    assign OWNER   = state_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        if (CE_R) begin
            case (state_q)
                IDLE: begin
                    if (M0_REQ && M1_REQ) begin
                        state_d = w_pick_m1 ? OWN1 : OWN0;
                        bcnt_d  = 2'd0;
                    end else if (M0_REQ) begin
                        state_d = OWN0;
                        bcnt_d  = 2'd0;
                    end else if (M1_REQ) begin
                        state_d = OWN1;
                        bcnt_d  = 2'd0;
                    end
                end
                OWN0, OWN1: begin
                    if (w_done) begin
                        if (w_burst && (bcnt_q != 2'd3)) begin
                            bcnt_d = bcnt_q + 2'd1;
                        end else if (w_lock) begin
                            // Locked: keep the bus, restart the line count.
                            bcnt_d = 2'd0;
                        end else begin
                            state_d = IDLE;
                            bcnt_d  = 2'd0;
                            last_d  = w_own1;
                        end
                    end else if (!w_req && !w_lock && (bcnt_q == 2'd0)) begin
                        // Request withdrawn outside a burst/lock.
                        state_d = IDLE;
                        last_d  = w_own1;
                    end
                    // Otherwise stall, locked gap, or mid-burst gap: hold.
                end
                default: begin
                    state_d = IDLE;
                    bcnt_d  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            bcnt_q  <= 2'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            last_q  <= last_d;
        end
    end

endmodule
`default_nettype wire
